// File: rtl/m_illegalop_stimgen.sv
// Stimulus generator for an RV32 illegal-instruction decoder: exhaustive opcode/funct sweep,
// then LFSR words, checked against a reference verdict. Macro MIDGETV_STIMGEN_MULDIV_EN enables M-extension rules.
module m_illegalop_stimgen #(
  parameter int unsigned NRAND = 4096,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] INSTR,
  output logic        corerunning,
  output logic        valid,
  input  logic        ready,
  input  logic        dut_illegal,
  output logic        expect_illegal,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_cnt,
  output logic [15:0] err_cnt,
  output logic [31:0] first_fail
);

`ifdef MIDGETV_STIMGEN_MULDIV_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [15:0] RAND_LAST = 16'(NRAND - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_RAND  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;
  logic [9:0]  idx_r;
  logic [15:0] rand_cnt_r;
  logic [31:0] lfsr_r;
  logic [31:0] instr_r, instr_nx_s;
  logic        valid_r, busy_r, done_r;
  logic [15:0] word_cnt_r, err_cnt_r;
  logic [31:0] first_fail_r;
  logic        start_run_s, transfer_s, mismatch_s;

  function automatic logic [31:0] lfsr_next_f(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

  // Index layout is {op, funct3, sel}; sel picks the funct7 flavour.
  function automatic logic [31:0] sweep_word_f(input logic [9:0] idx);
    logic [6:0] f7;
    case (idx[1:0])
      2'b00:   f7 = 7'h00;
      2'b01:   f7 = 7'h20;
      2'b10:   f7 = 7'h01;
      default: f7 = 7'h40;
    endcase
    return {f7, 5'd1, 5'd0, idx[4:2], 5'd0, idx[9:5], 2'b11};
  endfunction

  function automatic logic illegal_f(input logic [31:0] w);
    logic       bad;
    logic [6:0] f7;
    logic [2:0] f3;
    f7  = w[31:25];
    f3  = w[14:12];
    bad = 1'b1;
    if (w[1:0] == 2'b11) begin
      case (w[6:2])
        5'b00000, 5'b00010, 5'b00011, 5'b00101, 5'b01000,
        5'b01101, 5'b11000, 5'b11001, 5'b11011: bad = 1'b0;
        5'b00100: bad = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                        ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20)) ||
                        (MULDIV_EN && f7[0]);
        5'b01100: bad = !((f7 == 7'h00) ||
                          ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                          (MULDIV_EN && (f7 == 7'h01)));
        5'b11100: bad = (f3[1:0] == 2'b00) && ((w[19:15] != 5'd0) || (w[11:7] != 5'd0));
        default:  bad = 1'b1;
      endcase
    end else begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  assign start_run_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign transfer_s  = valid_r & ready;
  assign mismatch_s  = transfer_s & (dut_illegal != expect_illegal);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and next presented word; the first RAND word is the freshly loaded seed
  always_comb begin
    state_nx_s = state_r;
    instr_nx_s = instr_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_run_s) begin
          state_nx_s = ST_SWEEP;
          instr_nx_s = sweep_word_f(10'd0);
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_SWEEP: begin
        if (transfer_s && (idx_r == 10'd1023)) begin
          state_nx_s = ST_RAND;
          instr_nx_s = lfsr_r;
        end else if (transfer_s) begin
          instr_nx_s = sweep_word_f(idx_r + 10'd1);
        end else begin
          instr_nx_s = instr_r;
        end
      end
      ST_RAND: begin
        if (transfer_s) begin
          instr_nx_s = lfsr_next_f(lfsr_r);
          if (rand_cnt_r == RAND_LAST) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_RAND;
          end
        end else begin
          instr_nx_s = instr_r;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath: word generation, counters and mismatch capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r        <= 10'd0;
      rand_cnt_r   <= 16'd0;
      lfsr_r       <= SEED;
      instr_r      <= 32'h0000_0000;
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      word_cnt_r   <= 16'd0;
      err_cnt_r    <= 16'd0;
      first_fail_r <= 32'h0000_0000;
    end else begin
      instr_r <= instr_nx_s;
      valid_r <= (state_nx_s == ST_SWEEP) || (state_nx_s == ST_RAND);
      busy_r  <= (state_nx_s == ST_SWEEP) || (state_nx_s == ST_RAND);
      done_r  <= (state_nx_s == ST_DONE);
      if (start_run_s) begin
        idx_r        <= 10'd0;
        rand_cnt_r   <= 16'd0;
        lfsr_r       <= SEED;
        word_cnt_r   <= 16'd0;
        err_cnt_r    <= 16'd0;
        first_fail_r <= 32'h0000_0000;
      end else begin
        if (transfer_s && (state_r == ST_SWEEP)) begin
          idx_r <= idx_r + 10'd1;
        end
        if (transfer_s && (state_r == ST_RAND)) begin
          rand_cnt_r <= rand_cnt_r + 16'd1;
          lfsr_r     <= lfsr_next_f(lfsr_r);
        end
        if (transfer_s) begin
          word_cnt_r <= word_cnt_r + 16'd1;
        end
        if (mismatch_s && (err_cnt_r != 16'hFFFF)) begin
          err_cnt_r <= err_cnt_r + 16'd1;
        end
        if (mismatch_s && (err_cnt_r == 16'd0)) begin
          first_fail_r <= instr_r;
        end
      end
    end
  end

  assign INSTR          = instr_r;
  assign valid          = valid_r;
  assign corerunning    = valid_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign word_cnt       = word_cnt_r;
  assign err_cnt        = err_cnt_r;
  assign first_fail     = first_fail_r;
  assign expect_illegal = illegal_f(instr_r);

endmodule

// File: tb/tb_m_illegalop_stimgen.sv
// Directed bench for m_illegalop_stimgen with a short random phase (NRAND=8).
module tb_m_illegalop_stimgen;
  localparam int NRAND = 8;
`ifdef MIDGETV_STIMGEN_MULDIV_EN
  localparam logic [31:0] MUL_ILL    = 32'd0;
  localparam logic [31:0] SWEEP_ERRS = 32'd665;
`else
  localparam logic [31:0] MUL_ILL    = 32'd1;
  localparam logic [31:0] SWEEP_ERRS = 32'd667;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic        tie = 1'b1;
  logic        dut_illegal;
  logic [31:0] INSTR;
  logic        corerunning, valid, expect_illegal, busy, done;
  logic [15:0] word_cnt, err_cnt;
  logic [31:0] first_fail;
  logic [31:0] held;
  int checks = 0;
  int errors = 0;
  int n;

  m_illegalop_stimgen #(.NRAND(NRAND), .SEED(32'h0000_0001)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .INSTR(INSTR), .corerunning(corerunning),
    .valid(valid), .ready(ready), .dut_illegal(dut_illegal), .expect_illegal(expect_illegal),
    .busy(busy), .done(done), .word_cnt(word_cnt), .err_cnt(err_cnt), .first_fail(first_fail)
  );

  assign dut_illegal = tie ? expect_illegal : 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_instr"}, INSTR, 32'h0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_corerun"}, {31'd0, corerunning}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_word"}, {16'd0, word_cnt}, 32'd0);
    check({tag, "_err"}, {16'd0, err_cnt}, 32'd0);
    check({tag, "_ff"}, first_fail, 32'h0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();
    check("idle_valid", {31'd0, valid}, 32'd0);
    ready = 1'b1;

    // full run with verdict echoed back; a stray start mid-sweep must be ignored
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (valid === 1'b1 && n < 5000) begin
      start = (n == 10);
      if (n == 0) begin
        check("s0_instr", INSTR, 32'h0010_0003);
        check("s0_exp", {31'd0, expect_illegal}, 32'd0);
        check("s0_busy", {31'd0, busy}, 32'd1);
        check("s0_corerun", {31'd0, corerunning}, 32'd1);
      end
      if (n == 1) check("s1_instr", INSTR, 32'h4010_0003);
      if (n == 32) begin
        check("op1_instr", INSTR, 32'h0010_0007);
        check("op1_exp", {31'd0, expect_illegal}, 32'd1);
      end
      if (n == 133) begin
        check("slli_f20_instr", INSTR, 32'h4010_1013);
        check("slli_f20_exp", {31'd0, expect_illegal}, 32'd1);
      end
      if (n == 149) begin
        check("srai_instr", INSTR, 32'h4010_5013);
        check("srai_exp", {31'd0, expect_illegal}, 32'd0);
      end
      if (n == 386) begin
        check("mul_instr", INSTR, 32'h0210_0033);
        check("mul_exp", {31'd0, expect_illegal}, MUL_ILL);
      end
      if (n == 896) begin
        check("ecall_instr", INSTR, 32'h0010_0073);
        check("ecall_exp", {31'd0, expect_illegal}, 32'd0);
      end
      if (n == 1024) begin
        check("rand0_instr", INSTR, 32'h0000_0001);
        check("rand0_exp", {31'd0, expect_illegal}, 32'd1);
      end
      if (n == 1025) begin
        check("rand1_instr", INSTR, 32'h8020_0003);
        check("rand1_exp", {31'd0, expect_illegal}, 32'd0);
      end
      n++;
      tick();
    end
    start = 1'b0;
    check("run_len", n, 32'd1032);
    check("end_done", {31'd0, done}, 32'd1);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_corerun", {31'd0, corerunning}, 32'd0);
    check("end_word", {16'd0, word_cnt}, 32'd1032);
    check("end_err", {16'd0, err_cnt}, 32'd0);
    check("end_ff", first_fail, 32'h0);

    // restart from DONE, then stall with ready 1-0-0-1
    start = 1'b1; tick(); start = 1'b0;
    check("rs_instr", INSTR, 32'h0010_0003);
    check("rs_word", {16'd0, word_cnt}, 32'd0);
    tick();
    check("st1_instr", INSTR, 32'h4010_0003);
    check("st1_word", {16'd0, word_cnt}, 32'd1);
    held = INSTR;
    ready = 1'b0; tick();
    check("st2_instr", INSTR, held);
    check("st2_exp", {31'd0, expect_illegal}, 32'd0);
    check("st2_word", {16'd0, word_cnt}, 32'd1);
    tick();
    check("st3_instr", INSTR, held);
    check("st3_word", {16'd0, word_cnt}, 32'd1);
    ready = 1'b1; tick();
    check("st4_instr", INSTR, 32'h0210_0003);
    check("st4_word", {16'd0, word_cnt}, 32'd2);

    // abort at word 500
    n = 0;
    while (word_cnt !== 16'd500 && n < 2000) begin
      tick();
      n++;
    end
    check("reach500", {16'd0, word_cnt}, 32'd500);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_valid", {31'd0, valid}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);

    // decoder stuck at "legal": every illegal sweep word is a mismatch
    tie = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("r2_instr", INSTR, 32'h0010_0003);
    for (int i = 0; i < 1024; i++) begin
      if (i == 32) check("err_before_op1", {16'd0, err_cnt}, 32'd0);
      if (i == 33) begin
        check("err_after_op1", {16'd0, err_cnt}, 32'd1);
        check("ff_after_op1", first_fail, 32'h0010_0007);
      end
      tick();
    end
    check("sw_word", {16'd0, word_cnt}, 32'd1024);
    check("sw_err", {16'd0, err_cnt}, SWEEP_ERRS);
    check("sw_ff", first_fail, 32'h0010_0007);
    check("sw_valid", {31'd0, valid}, 32'd1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("r2_done", {31'd0, done}, 32'd1);
    check("r2_word", {16'd0, word_cnt}, 32'd1032);
    check("r2_ff", first_fail, 32'h0010_0007);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/m_illegalop_stimgen.md
M_ILLEGALOP_STIMGEN -- requirements
Module: m_illegalop_stimgen

Interface
REQ-001 Parameter NRAND, default 4096: number of random-phase words, 1..65535.
REQ-002 Parameter SEED, default 32'h0000_0001: LFSR seed; nonzero.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-006 INSTR  output  32  instruction word presented to the illegal-op decoder under test.
REQ-007 corerunning  output  1  high while valid is high, otherwise low.
REQ-008 valid  output  1  INSTR, expect_illegal and corerunning are meaningful.
REQ-009 ready  input  1  consumer accepts the word; transfer occurs when valid&ready.
REQ-010 dut_illegal  input  1  decoder verdict for INSTR, sampled at transfer.
REQ-011 expect_illegal  output  1  reference-model verdict for INSTR.
REQ-012 busy  output  1  state is SWEEP or RAND.
REQ-013 done  output  1  state is DONE.
REQ-014 word_cnt  output  16  transfers completed in the current run, wraps at 16'hFFFF.
REQ-015 err_cnt  output  16  transfers where dut_illegal != expect_illegal; saturates at 16'hFFFF.
REQ-016 first_fail  output  32  INSTR of the first mismatch in the run; 0 if none.

Function
REQ-017 FSM states are IDLE, SWEEP, RAND and DONE; start in IDLE or DONE -> SWEEP, clearing word_cnt, err_cnt, first_fail and the sweep index, and reloading the LFSR with SEED.
REQ-018 start is ignored in SWEEP and RAND.
REQ-019 SWEEP uses a 10-bit index {op[4:0], f3[2:0], sel[1:0]}.
REQ-020 In SWEEP, INSTR = {f7, 5'd1, 5'd0, f3, 5'd0, op, 2'b11}, with f7 chosen by sel: 00->7'h00, 01->7'h20, 10->7'h01, 11->7'h40.
REQ-021 The sweep index increments by 1 per transfer.
REQ-022 After the transfer at index 1023, the FSM goes to RAND.
REQ-023 In RAND, INSTR = LFSR state; the LFSR is 32-bit Galois, taps x^32+x^22+x^2+x+1, and advances once per transfer.
REQ-024 RAND ends after NRAND transfers, then the FSM goes to DONE.
REQ-025 valid is high in SWEEP and RAND, low in IDLE and DONE.
REQ-026 While valid & ~ready, INSTR and expect_illegal shall hold stable.
REQ-027 The first word is presented the cycle after start; with ready tied high, one transfer occurs per cycle and there are no bubbles at the SWEEP->RAND boundary.
REQ-028 expect_illegal is combinational from INSTR; it is 1 unless INSTR[1:0]=11 and INSTR[6:2] is one of 00000, 00010, 00011, 00100, 00101, 01000, 01100, 01101, 11000, 11001, 11011, 11100.
REQ-029 expect_illegal is additionally 1 for OP-IMM (00100) with funct3=001 and funct7!=0.
REQ-030 expect_illegal is additionally 1 for OP-IMM with funct3=101 and funct7 not in {00h, 20h}.
REQ-031 expect_illegal is additionally 1 for OP (01100) when funct7 is not 00h, or 20h with funct3 in {000,101}, or 01h per REQ-040.
REQ-032 expect_illegal is additionally 1 for SYSTEM (11100) with funct3[1:0]=00 and (rs1!=0 or rd!=0).
REQ-033 At each transfer, if dut_illegal!=expect_illegal: err_cnt increments (saturating), and first_fail is captured only when err_cnt was 0.
REQ-034 When a mismatch and the final transfer of a phase coincide, the count is applied before the phase change.

Reset
REQ-035 On rst_n low, asynchronously: state=IDLE, valid=0, corerunning=0, busy=0, done=0, INSTR=0, word_cnt=0, err_cnt=0, first_fail=0, LFSR=SEED, sweep index=0.
REQ-036 Reset asserted mid-run aborts the run; there is no transfer in that cycle, and after release the block waits in IDLE for start.

Configuration
REQ-037 Macro MIDGETV_STIMGEN_MULDIV_EN selects the M-extension behaviour.
REQ-038 With MIDGETV_STIMGEN_MULDIV_EN defined: OP with funct7=01h is legal for all funct3 (mul..remu).
REQ-039 With MIDGETV_STIMGEN_MULDIV_EN defined: OP-IMM with funct7[0]=1 is illegal.
REQ-040 Without MIDGETV_STIMGEN_MULDIV_EN: OP with funct7=01h is illegal; all other rules are unchanged.

Verification
REQ-041 Scenario: reset, start, ready=1, dut_illegal tied to expect_illegal -> valid for exactly 1024+NRAND cycles, then done=1, word_cnt=1024+NRAND, err_cnt=0.
REQ-042 Scenario: sweep index 0 -> INSTR=32'h0010_0003, expect_illegal=0; index for op=00001 -> expect_illegal=1.
REQ-043 Scenario: INSTR=32'h0210_0033 (mul) -> expect_illegal=0 with MIDGETV_STIMGEN_MULDIV_EN, 1 without.
REQ-044 Scenario: dut_illegal forced to 0 -> err_cnt counts illegal words; first_fail=32'h0010_0007 (first illegal sweep word, op=00001).
REQ-045 Scenario: ready toggled 1-0-0-1 -> INSTR held stable across the stall; word_cnt increments only on the two transfers.
REQ-046 Scenario: rst_n pulsed low at word_cnt=500 -> all outputs at reset values; a later start restarts with INSTR=32'h0010_0003.
